// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge
//
// Memory-side responder for the CPU load/store path. One word-aligned access
// (per-lane write enables plus lane-positioned write data) is serialized onto
// an 8-bit external bus with a req/ack handshake, one byte lane per transfer,
// lanes issued in ascending order. Reads gather all four bytes into a raw
// 32-bit word; the CPU-side load formatter does any shifting/sign-extension.
//
// Ports
//   i_clk, i_rst      clock and synchronous active-high reset
//   i_req             access request, sampled only while idle
//   i_addr            access address, bits [1:0] ignored
//   i_we              byte-lane write enables, 4'b0000 reads all four lanes
//   i_data_wr         write data, lane n in bits [8n+7:8n]
//   o_busy            high while transfers are in flight (CPU stalls)
//   o_done            one-cycle completion pulse
//   o_data_rd         gathered read word, held until overwritten by a read
//   o_mem_req         external transfer request
//   o_mem_we          external write strobe, qualifies o_mem_req
//   o_mem_addr        external byte address {addr[ADDR_W-1:2], lane}
//   o_mem_data_wr     external write byte
//   i_mem_data_rd     external read byte, valid in the ack cycle
//   i_mem_ack         transfer completes when o_mem_req && i_mem_ack
//
// All outputs come straight from flops.

module mem_byte_bridge #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_data_wr,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_data_rd,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data_wr,
    input  logic [7:0]        i_mem_data_rd,
    input  logic              i_mem_ack
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State and latched access
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [3:0]          lanes_q, lanes_d;     // lanes still to transfer
    logic [1:0]          lane_q, lane_d;       // lane currently on the bus
    logic                read_q, read_d;
    logic [ADDR_W-3:0]   addr_hi_q, addr_hi_d;
    logic [31:0]         wdata_q, wdata_d;

    // Registered outputs
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         data_rd_q, data_rd_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_data_wr_q, mem_data_wr_d;

    // The address is word aligned; the low bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[1:0];

    // Lowest set lane of a mask; callers guarantee the mask is nonzero.
    function automatic logic [1:0] low_lane(input logic [3:0] mask);
        if (mask[0]) begin
            return 2'd0;
        end else if (mask[1]) begin
            return 2'd1;
        end else if (mask[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic       accept;
    logic       ack_fire;
    logic       req_read;
    logic [3:0] req_lanes;
    logic [1:0] first_lane;
    logic [3:0] rem_lanes;
    logic [1:0] next_lane;
    logic       last_lane;

    assign accept     = (state_q == StIdle) && i_req;
    assign ack_fire   = (state_q == StAccess) && mem_req_q && i_mem_ack;
    assign req_read   = (i_we == 4'b0000);
    // A read has no enables of its own, so it walks all four lanes.
    assign req_lanes  = req_read ? 4'b1111 : i_we;
    assign first_lane = low_lane(req_lanes);
    assign rem_lanes  = lanes_q & ~(4'b0001 << lane_q);
    assign next_lane  = low_lane(rem_lanes);
    assign last_lane  = (rem_lanes == 4'b0000);

    // ------------------------------------------------------------------
    // State register (synchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            lanes_q       <= 4'b0000;
            lane_q        <= 2'd0;
            read_q        <= 1'b0;
            addr_hi_q     <= '0;
            wdata_q       <= 32'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            data_rd_q     <= 32'h0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_wr_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            lanes_q       <= lanes_d;
            lane_q        <= lane_d;
            read_q        <= read_d;
            addr_hi_q     <= addr_hi_d;
            wdata_q       <= wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            data_rd_q     <= data_rd_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_wr_q <= mem_data_wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lanes_d   = lanes_q;
        lane_d    = lane_q;
        read_d    = read_q;
        addr_hi_d = addr_hi_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StAccess;
                    lanes_d   = req_lanes;
                    lane_d    = first_lane;
                    read_d    = req_read;
                    addr_hi_d = i_addr[ADDR_W-1:2];
                    wdata_d   = i_data_wr;
                end
            end
            StAccess: begin
                if (ack_fire) begin
                    lanes_d = rem_lanes;
                    if (last_lane) begin
                        state_d = StDone;
                    end else begin
                        lane_d = next_lane;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_d        = busy_q;
        done_d        = 1'b0;
        data_rd_d     = data_rd_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_data_wr_d = mem_data_wr_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    busy_d        = 1'b1;
                    mem_req_d     = 1'b1;
                    mem_we_d      = ~req_read;
                    mem_addr_d    = {i_addr[ADDR_W-1:2], first_lane};
                    mem_data_wr_d = i_data_wr[{first_lane, 3'b000} +: 8];
                end
            end
            StAccess: begin
                // Without an ack every bus output simply holds.
                if (ack_fire) begin
                    if (read_q) begin
                        data_rd_d[{lane_q, 3'b000} +: 8] = i_mem_data_rd;
                    end
                    if (last_lane) begin
                        busy_d    = 1'b0;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        mem_addr_d    = {addr_hi_q, next_lane};
                        mem_data_wr_d = wdata_q[{next_lane, 3'b000} +: 8];
                    end
                end
            end
            StDone: begin
                done_d = 1'b0;
            end
            default: begin
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_data_rd     = data_rd_q;
    assign o_mem_req     = mem_req_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_data_wr = mem_data_wr_q;

endmodule

// File: tb/tb_mem_byte_bridge.sv
module tb_mem_byte_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [3:0]  we = 4'b0000;
    logic [31:0] data_wr = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] data_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_wr;
    logic [7:0]  mem_data_rd;
    logic        mem_ack;

    int n_vec = 0;
    int n_err = 0;

    // Read-only byte memory and write log
    logic [7:0]  rom [1024];
    logic [31:0] wr_addr_log [$];
    logic [7:0]  wr_data_log [$];

    // Ack model: ack after ack_delay wait cycles of a held request
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt = 0;

    assign mem_data_rd = rom[mem_addr[9:0]];
    assign mem_ack     = ack_en && (wait_cnt >= ack_delay);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && mem_ack) wait_cnt <= 0;
        else if (mem_req)       wait_cnt <= wait_cnt + 1;
        else                    wait_cnt <= 0;
        if (mem_req && mem_ack && mem_we && !rst) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_data_wr);
        end
    end

    mem_byte_bridge #(.ADDR_W(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_addr        (addr),
        .i_we          (we),
        .i_data_wr     (data_wr),
        .o_busy        (busy),
        .o_done        (done),
        .o_data_rd     (data_rd),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_data_wr (mem_data_wr),
        .i_mem_data_rd (mem_data_rd),
        .i_mem_ack     (mem_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_vec++; if (mem_data_wr !== 8'h0) begin n_err++; $display("FAIL rst_mem_data_wr: got %h want 0", mem_data_wr); end
        n_vec++; if (data_rd !== 32'h0) begin n_err++; $display("FAIL rst_data_rd: got %h want 0", data_rd); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_basic();
        addr = 32'h100; we = 4'b0000; req = 1'b1;
        step();                       // T+1
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (mem_req !== 1'b1 || busy !== 1'b1) begin
                n_err++; $display("FAIL rd_req lane%0d: got req=%b busy=%b want 1,1", i, mem_req, busy); end
            n_vec++; if (mem_addr !== 32'h100 + i) begin
                n_err++; $display("FAIL rd_addr lane%0d: got %h want %h", i, mem_addr, 32'h100 + i); end
            n_vec++; if (mem_we !== 1'b0) begin
                n_err++; $display("FAIL rd_we lane%0d: got %b want 0", i, mem_we); end
            step();
        end
        // T+5
        n_vec++; if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL rd_done: got done=%b busy=%b req=%b want 1,0,0", done, busy, mem_req); end
        n_vec++; if (data_rd !== 32'h44332211) begin
            n_err++; $display("FAIL rd_data: got %h want 44332211", data_rd); end
        step();                       // T+6
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rd_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_write_lanes();
        int base;
        base = wr_addr_log.size();
        addr = 32'h203; we = 4'b0110; data_wr = 32'hAABBCCDD; req = 1'b1;
        step();                       // T+1
        req = 1'b0; we = 4'b0000;
        n_vec++; if (mem_addr !== 32'h201 || mem_data_wr !== 8'hCC || mem_we !== 1'b1) begin
            n_err++; $display("FAIL wr_first: got %h/%h we=%b want 201/cc we=1", mem_addr, mem_data_wr, mem_we); end
        step();                       // T+2
        n_vec++; if (mem_addr !== 32'h202 || mem_data_wr !== 8'hBB || mem_we !== 1'b1) begin
            n_err++; $display("FAIL wr_second: got %h/%h we=%b want 202/bb we=1", mem_addr, mem_data_wr, mem_we); end
        step();                       // T+3
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL wr_done: got done=%b busy=%b want 1,0", done, busy); end
        n_vec++; if (wr_addr_log.size() - base !== 2) begin
            n_err++; $display("FAIL wr_count: got %0d want 2", wr_addr_log.size() - base); end
        else begin
            n_vec++; if (wr_addr_log[base] !== 32'h201 || wr_data_log[base] !== 8'hCC ||
                         wr_addr_log[base+1] !== 32'h202 || wr_data_log[base+1] !== 8'hBB) begin
                n_err++; $display("FAIL wr_log: got %h<-%h %h<-%h want 201<-cc 202<-bb",
                    wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1], wr_data_log[base+1]); end
        end
        n_vec++; if (data_rd !== 32'h44332211) begin
            n_err++; $display("FAIL wr_keeps_rd: got %h want 44332211", data_rd); end
        step();
    endtask

    task automatic test_read_delayed();
        int busy_cnt = 0;
        ack_delay = 3;
        addr = 32'h300; we = 4'b0000; req = 1'b1;
        step();                       // T+1
        req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (busy === 1'b1) busy_cnt++;
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 + (i / 4)) begin
                n_err++; $display("FAIL dly_hold cyc%0d: got req=%b addr=%h want 1/%h",
                    i, mem_req, mem_addr, 32'h300 + (i / 4)); end
            step();
        end
        // T+17
        n_vec++; if (busy_cnt !== 16) begin n_err++; $display("FAIL dly_busy_cycles: got %0d want 16", busy_cnt); end
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL dly_done: got done=%b busy=%b want 1,0", done, busy); end
        n_vec++; if (data_rd !== 32'hD4C3B2A1) begin
            n_err++; $display("FAIL dly_data: got %h want d4c3b2a1", data_rd); end
        ack_delay = 0;
        step();
    endtask

    task automatic test_back_to_back();
        addr = 32'h100; we = 4'b0000; req = 1'b1;
        step();                       // T+1
        addr = 32'h200;               // must not disturb the access in flight
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (mem_addr !== 32'h100 + i) begin
                n_err++; $display("FAIL b2b_first lane%0d: got %h want %h", i, mem_addr, 32'h100 + i); end
            step();
        end
        // T+5: DONE ignores the held request
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_done: got done=%b busy=%b want 1,0", done, busy); end
        step();                       // T+6: idle, accepting
        n_vec++; if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL b2b_gap: got busy=%b req=%b done=%b want 0,0,0", busy, mem_req, done); end
        step();                       // T+7
        req = 1'b0;
        n_vec++; if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            n_err++; $display("FAIL b2b_second: got busy=%b req=%b addr=%h want 1,1,200", busy, mem_req, mem_addr); end
        for (int i = 0; i < 4; i++) step();  // T+11
        n_vec++; if (done !== 1'b1 || data_rd !== 32'h04030201) begin
            n_err++; $display("FAIL b2b_data: got done=%b data=%h want 1/04030201", done, data_rd); end
        step();
    endtask

    task automatic test_reset_mid();
        addr = 32'h300; we = 4'b0000; req = 1'b1;
        step();                       // T+1 lane 0
        req = 1'b0;
        step();                       // T+2 lane 1
        step();                       // T+3 lane 2, ack pending
        n_vec++; if (mem_addr !== 32'h302) begin
            n_err++; $display("FAIL rmid_lane2: got %h want 302", mem_addr); end
        rst = 1'b1;
        step();                       // T+4
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            n_err++; $display("FAIL rmid_ctrl: got busy=%b done=%b req=%b we=%b want 0", busy, done, mem_req, mem_we); end
        n_vec++; if (mem_addr !== 32'h0 || mem_data_wr !== 8'h0 || data_rd !== 32'h0) begin
            n_err++; $display("FAIL rmid_data: got addr=%h wd=%h rd=%h want 0", mem_addr, mem_data_wr, data_rd); end
        rst = 1'b0;
        step();
        n_vec++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL rmid_idle: got busy=%b req=%b want 0,0", busy, mem_req); end
        addr = 32'h100; req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_vec++; if (done !== 1'b1 || data_rd !== 32'h44332211) begin
            n_err++; $display("FAIL rmid_fresh: got done=%b data=%h want 1/44332211", done, data_rd); end
        step();
    endtask

    task automatic test_write_single();
        addr = 32'h104; we = 4'b1000; data_wr = 32'h5A000000; req = 1'b1;
        step();                       // T+1
        req = 1'b0; we = 4'b0000;
        n_vec++; if (mem_addr !== 32'h107 || mem_data_wr !== 8'h5A || mem_we !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL ws_xfer: got %h/%h we=%b busy=%b want 107/5a 1 1",
                mem_addr, mem_data_wr, mem_we, busy); end
        step();                       // T+2
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL ws_done: got done=%b busy=%b want 1,0", done, busy); end
        n_vec++; if (data_rd !== 32'h44332211) begin
            n_err++; $display("FAIL ws_keeps_rd: got %h want 44332211", data_rd); end
        step();                       // T+3
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL ws_pulse: got %b want 0", done); end
        addr = 32'h104; req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_vec++; if (done !== 1'b1 || data_rd !== 32'h40302010) begin
            n_err++; $display("FAIL ws_read_after: got done=%b data=%h want 1/40302010", done, data_rd); end
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        rom[10'h100] = 8'h11; rom[10'h101] = 8'h22; rom[10'h102] = 8'h33; rom[10'h103] = 8'h44;
        rom[10'h104] = 8'h10; rom[10'h105] = 8'h20; rom[10'h106] = 8'h30; rom[10'h107] = 8'h40;
        rom[10'h200] = 8'h01; rom[10'h201] = 8'h02; rom[10'h202] = 8'h03; rom[10'h203] = 8'h04;
        rom[10'h300] = 8'hA1; rom[10'h301] = 8'hB2; rom[10'h302] = 8'hC3; rom[10'h303] = 8'hD4;

        test_reset();
        test_read_basic();
        test_write_lanes();
        test_read_delayed();
        test_back_to_back();
        test_reset_mid();
        test_write_single();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
